// File: rtl/uart_cmd_frame_tx_if.sv
// Command handshake bundle between the host sequencer and the UART frame serializer.
interface uart_cmd_frame_tx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int BAUD_DIV_WIDTH = 16
);
    logic                      i_cmd_valid;
    logic                      o_cmd_ready;
    logic [1:0]                i_cmd_type;
    logic [ADDR_WIDTH-1:0]     i_addr;
    logic [DATA_WIDTH-1:0]     i_data0;
    logic [DATA_WIDTH-1:0]     i_data1;
    logic [ALU_FUN_WIDTH-1:0]  i_alu_fun;
    logic                      i_par_en;
    logic                      i_par_typ;
    logic [BAUD_DIV_WIDTH-1:0] i_baud_div;

    modport master (
        output i_cmd_valid, i_cmd_type, i_addr, i_data0, i_data1, i_alu_fun,
               i_par_en, i_par_typ, i_baud_div,
        input  o_cmd_ready
    );

    modport slave (
        input  i_cmd_valid, i_cmd_type, i_addr, i_data0, i_data1, i_alu_fun,
               i_par_en, i_par_typ, i_baud_div,
        output o_cmd_ready
    );
endinterface

// File: rtl/uart_cmd_frame_tx.sv
// Expands one host command into its controller byte sequence and sends it as
// back-to-back UART frames (start, 8 data LSB first, optional parity, stop).
module uart_cmd_frame_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int BAUD_DIV_WIDTH = 16
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    uart_cmd_frame_tx_if.slave  cmd_if,
    output logic                o_TX_OUT,
    output logic                o_busy,
    output logic                o_frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                          r_state, w_state_nxt;
    logic [BAUD_DIV_WIDTH-1:0]       r_cnt, w_cnt_nxt, r_bm1, w_bm1_cmd;
    logic [2:0]                      r_bit, w_bit_nxt;
    logic [1:0]                      r_byte, w_byte_nxt, r_nm1, w_nm1_cmd;
    logic [3:0][DATA_WIDTH-1:0]      r_bytes, w_bytes_cmd;
    logic                            r_par_en, r_par_typ, r_tx, w_tx_nxt;
    logic                            w_accept, w_cnt_end, w_par_bit;
    logic [DATA_WIDTH-1:0]           w_cur, w_addr_ext, w_fun_ext;
    logic [ADDR_WIDTH-1:0]           w_addr;
    logic [ALU_FUN_WIDTH-1:0]        w_fun;

    assign cmd_if.o_cmd_ready = (r_state == S_IDLE);
    assign o_busy             = (r_state != S_IDLE);
    assign o_TX_OUT           = r_tx;

    assign w_accept   = cmd_if.i_cmd_valid && (r_state == S_IDLE);
    assign w_cnt_end  = (r_cnt == r_bm1);
    assign w_addr     = cmd_if.i_addr;
    assign w_fun      = cmd_if.i_alu_fun;
    assign w_addr_ext = DATA_WIDTH'(w_addr);
    assign w_fun_ext  = DATA_WIDTH'(w_fun);
    assign w_cur      = r_bytes[r_byte];
    assign w_par_bit  = (^w_cur) ^ r_par_typ;
    // Divider is stored as B-1 so a full-scale divide never overflows the counter.
    assign w_bm1_cmd  = (cmd_if.i_baud_div == '0) ? '0
                      : cmd_if.i_baud_div - BAUD_DIV_WIDTH'(1);

    assign o_frame_done = (r_state == S_STOP) && w_cnt_end && (r_byte == r_nm1);

    always_comb begin
        w_bytes_cmd = '0;
        w_nm1_cmd   = 2'd1;
        case (cmd_if.i_cmd_type)
            2'd0: begin
                w_bytes_cmd = {DATA_WIDTH'(0), cmd_if.i_data0, w_addr_ext, DATA_WIDTH'(8'hAA)};
                w_nm1_cmd   = 2'd2;
            end
            2'd1: begin
                w_bytes_cmd = {DATA_WIDTH'(0), DATA_WIDTH'(0), w_addr_ext, DATA_WIDTH'(8'hBB)};
                w_nm1_cmd   = 2'd1;
            end
            2'd2: begin
                w_bytes_cmd = {w_fun_ext, cmd_if.i_data1, cmd_if.i_data0, DATA_WIDTH'(8'hCC)};
                w_nm1_cmd   = 2'd3;
            end
            default: begin
                w_bytes_cmd = {DATA_WIDTH'(0), DATA_WIDTH'(0), w_fun_ext, DATA_WIDTH'(8'hDD)};
                w_nm1_cmd   = 2'd1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        if (r_state != S_IDLE)
            w_cnt_nxt = w_cnt_end ? '0 : r_cnt + BAUD_DIV_WIDTH'(1);
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_bit_nxt   = 3'd0;
                    w_byte_nxt  = 2'd0;
                end
            end
            S_START: if (w_cnt_end) begin
                w_state_nxt = S_DATA;
                w_bit_nxt   = 3'd0;
            end
            S_DATA: if (w_cnt_end) begin
                if (r_bit == 3'd7) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                else               w_bit_nxt   = r_bit + 3'd1;
            end
            S_PARITY: if (w_cnt_end) w_state_nxt = S_STOP;
            S_STOP: if (w_cnt_end) begin
                if (r_byte == r_nm1) w_state_nxt = S_IDLE;
                else begin
                    w_state_nxt = S_START;
                    w_byte_nxt  = r_byte + 2'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line level is decoded from the next state so the registered output lines up with it.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_cur[w_bit_nxt];
            S_PARITY: w_tx_nxt = w_par_bit;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_tx      <= 1'b1;
            r_bytes   <= '0;
            r_nm1     <= '0;
            r_bm1     <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_tx    <= w_tx_nxt;
            if (w_accept) begin
                r_bytes   <= w_bytes_cmd;
                r_nm1     <= w_nm1_cmd;
                r_bm1     <= w_bm1_cmd;
                r_par_en  <= cmd_if.i_par_en;
                r_par_typ <= cmd_if.i_par_typ;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Directed bench: commands push expected frames into a scoreboard that a
// line-level UART decoder pops and checks bit by bit.
module tb_uart_cmd_frame_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, busy, done;

    uart_cmd_frame_tx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .BAUD_DIV_WIDTH(16)) cif();

    uart_cmd_frame_tx #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .BAUD_DIV_WIDTH(16)) dut (
        .i_CLK(clk), .i_RST(rst), .cmd_if(cif),
        .o_TX_OUT(tx), .o_busy(busy), .o_frame_done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       pe;
        logic       pt;
        int         bdiv;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Line decoder: samples every cycle of every bit at the negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                chk("mon_q_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t       e;
                    logic [10:0] bits;
                    logic       stable;
                    int         nb;
                    e      = sb.pop_front();
                    nb     = e.pe ? 11 : 10;
                    bits   = '0;
                    stable = 1'b1;
                    for (int k = 0; k < nb; k++) begin
                        for (int c = 0; c < e.bdiv; c++) begin
                            if (!(k == 0 && c == 0)) @(negedge clk);
                            if (c == 0) bits[k] = tx;
                            else if (tx !== bits[k]) stable = 1'b0;
                        end
                    end
                    chk("mon_byte", int'(bits[8:1]), int'(e.b));
                    if (e.pe) chk("mon_parity", int'(bits[9]), int'((^e.b) ^ e.pt));
                    chk("mon_stop", int'(bits[nb-1]), 1);
                    chk("mon_bit_stable", int'(stable), 1);
                end
            end
        end
    end

    task automatic run_cmd(input string tag, input logic [1:0] typ, input logic [3:0] addr,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] fun,
                           input logic pe, input logic pt, input logic [15:0] div,
                           input bit hold, input bit mutate, input int exp_cycles);
        logic [7:0] bq[$];
        int n;
        bit done_seen, ready_seen;
        case (typ)
            2'd0: bq = '{8'hAA, {4'h0, addr}, d0};
            2'd1: bq = '{8'hBB, {4'h0, addr}};
            2'd2: bq = '{8'hCC, d0, d1, {4'h0, fun}};
            default: bq = '{8'hDD, {4'h0, fun}};
        endcase
        foreach (bq[i]) sb.push_back('{b: bq[i], pe: pe, pt: pt, bdiv: (div == 0) ? 1 : int'(div)});
        @(negedge clk);
        cif.i_cmd_valid = 1'b1; cif.i_cmd_type = typ; cif.i_addr = addr;
        cif.i_data0 = d0; cif.i_data1 = d1; cif.i_alu_fun = fun;
        cif.i_par_en = pe; cif.i_par_typ = pt; cif.i_baud_div = div;
        @(posedge clk);
        n = 0; done_seen = 0; ready_seen = 0;
        while (n < 5000 && !done_seen) begin
            @(negedge clk);
            n++;
            if (!hold) cif.i_cmd_valid = 1'b0;
            if (mutate && n == 5) begin
                cif.i_baud_div = 16'd1; cif.i_par_en = ~pe; cif.i_par_typ = ~pt;
                cif.i_data0 = ~d0; cif.i_addr = ~addr; cif.i_cmd_type = ~typ;
            end
            if (done === 1'b1) done_seen = 1;
            else if (cif.o_cmd_ready !== 1'b0 || busy !== 1'b1) ready_seen = 1;
        end
        cif.i_cmd_valid = 1'b0;
        chk({tag, "_done_latency"}, n, exp_cycles);
        chk({tag, "_busy_during"}, int'(ready_seen), 0);
        chk({tag, "_sb_drained"}, sb.size(), 0);
        @(negedge clk);
        chk({tag, "_ready_after"}, int'(cif.o_cmd_ready), 1);
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_line_idle"}, int'(tx), 1);
    endtask

    initial begin
        int pulses;
        cif.i_cmd_valid = 1'b0; cif.i_cmd_type = '0; cif.i_addr = '0;
        cif.i_data0 = '0; cif.i_data1 = '0; cif.i_alu_fun = '0;
        cif.i_par_en = 1'b0; cif.i_par_typ = 1'b0; cif.i_baud_div = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(cif.o_cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_line", int'(tx), 1);
        mon_en = 1'b1;

        run_cmd("rf_wr", 2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b1, 1'b0, 16'd4, 0, 0, 132);
        run_cmd("rf_rd", 2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 16'd1, 0, 0, 22);
        run_cmd("alu_op", 2'd2, 4'h0, 8'h12, 8'h34, 4'h2, 1'b0, 1'b0, 16'd0, 1, 0, 40);
        run_cmd("mut", 2'd0, 4'h9, 8'hA5, 8'h00, 4'h0, 1'b1, 1'b0, 16'd3, 0, 1, 99);
        run_cmd("big_div", 2'd3, 4'h0, 8'h00, 8'h00, 4'hB, 1'b1, 1'b1, 16'd7, 0, 0, 154);

        // Reset in the middle of byte 1 of an ALU_NOP; decoder disabled for the aborted frame.
        mon_en = 1'b0;
        @(negedge clk);
        cif.i_cmd_valid = 1'b1; cif.i_cmd_type = 2'd3; cif.i_alu_fun = 4'h7;
        cif.i_par_en = 1'b0; cif.i_par_typ = 1'b0; cif.i_baud_div = 16'd2;
        @(posedge clk);
        @(negedge clk);
        cif.i_cmd_valid = 1'b0;
        pulses = 0;
        repeat (24) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("mid_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", int'(tx), 1);
        chk("mid_rst_ready", int'(cif.o_cmd_ready), 1);
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1 || tx !== 1'b1) pulses++;
        end
        chk("mid_no_done_or_resume", pulses, 0);
        mon_en = 1'b1;
        run_cmd("post_rst_rd", 2'd1, 4'h3, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 16'd2, 0, 0, 44);

        repeat (5) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
